imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that acts as the writer side of the processor's instruction-memory load port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the load-enable, address and data inputs of the core's load port.
- Holds the core in reset until the whole image is written, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 1024, largest accepted image size in words; a larger header count is an error.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream payload.
- in_ready  output  1  loader can accept a byte this cycle.
- loadIM  output  1  instruction-memory write strobe to the core's load port.
- addr  output  32  instruction-memory byte address, valid while loadIM=1.
- data  output  32  instruction word, valid while loadIM=1.
- core_rst  output  1  active-high reset to the processor; 1 = hold the core.
- busy  output  1  load in progress (HDR, DATA or WRITE).
- done  output  1  image fully loaded; core released.
- err  output  1  header rejected.
- words_loaded  output  16  count of words written so far.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=0, loadIM=0, addr=0, data=0, core_rst=1, busy=0, done=0, err=0, words_loaded=0, byte counter=0, word index=0.
- Handshake: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready=1 only in HDR and DATA. Stalls (in_valid=0) may be of any length and do not change state.
- Byte order: little-endian. The first accepted byte is bits [7:0], the fourth is bits [31:24]. A 2-bit byte counter wraps 3->0 on each completed word.
- IDLE:
  - outputs core_rst=1, done=0, err=0.
  - start=1 -> HDR; byte counter and words_loaded are cleared.
- HDR: collects 4 bytes to form the header word H. On the 4th byte:
  - H[31:16]!=0 or H[15:0]>MAX_WORDS -> ERR.
  - H[15:0]==0 -> DONE.
  - otherwise latch N=H[15:0], word index=0 -> DATA.
- DATA: collects 4 bytes into the word register. On acceptance of the 4th byte -> WRITE on the next cycle.
- WRITE: lasts exactly one cycle.
  - outputs loadIM=1, addr=BASE_ADDR + 4*index (32-bit, wraps modulo 2^32), data=assembled word, in_ready=0.
  - next edge: index and words_loaded increment; index==N -> DONE, else -> DATA.
  - loadIM is 0 in every other state; addr and data hold their last values.
- Latency: the 4th byte of word k is accepted at edge t; loadIM for word k is high in the cycle after edge t; the earliest byte of word k+1 is accepted at edge t+2.
- DONE: core_rst=0, done=1, busy=0. Outputs hold until start=1, which restarts at HDR with core_rst=1 re-asserted in the following cycle.
- ERR: err=1, core_rst=1, in_ready=0. Exit only on start=1 (-> HDR, err cleared) or on reset.
- start while busy is ignored. in_valid outside HDR/DATA is ignored; no byte is consumed.
- Reset mid-load: everything returns to the reset values immediately. Memory already written is not erased; words_loaded reads 0.
- busy=1 exactly in HDR, DATA and WRITE.

Test Plan:
- Basic load:
  - stimulus: reset, start, bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 with in_valid held high.
  - required response: loadIM pulses twice — addr=0x0 data=0x00100513, then addr=0x4 data=0x00200593. Then done=1, core_rst=0, words_loaded=2.
- Stall tolerance: same stream with in_valid low for 3 random cycles between bytes -> identical loadIM writes; in_ready never drops during a stall in DATA.
- Header errors:
  - header 01 04 00 00 (1025 > MAX_WORDS) -> err=1, core_rst=1, no loadIM pulse.
  - header 00 00 01 00 -> ERR.
  - start afterwards -> HDR with err=0.
- Zero-length image: header 00 00 00 00 -> DONE directly after the 4th byte; no loadIM pulse; words_loaded=0.
- Reset mid-load: rst_n low during the second data byte of word 1 of 3 -> all outputs at reset values immediately. A fresh start with a 1-word image then writes that word at addr=BASE_ADDR.
- Reload and BASE_ADDR:
  - with BASE_ADDR=0x100, load 1 word (addr=0x100), then start again and load 3 words.
  - required response: addresses 0x100, 0x104, 0x108; core_rst is 1 throughout the second load; start during the second load is ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory load port of the boot loader.
// master = the loader; slave = the stream source plus the core's load port.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        loadIM;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (
        input  in_valid, in_data,
        output in_ready, loadIM, addr, data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, loadIM, addr, data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them
// through the core's load port and holds the core in reset until the image is in.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_loader_if.master      ld,
    output logic               core_rst,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        words_loaded
);
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_lo;
    logic [15:0] n_words;
    logic [15:0] idx;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    logic        accept;
    logic        last_byte;
    logic        start_ok;
    logic        hdr_bad;
    logic [31:0] word_full;

    // the 4th byte is used straight off the bus, so only three bytes are stored
    assign accept    = ld.in_valid & ld.in_ready;
    assign last_byte = accept & (byte_cnt == 2'd3);
    assign word_full = {ld.in_data, word_lo};
    assign start_ok  = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign hdr_bad   = (word_full[31:16] != 16'd0) | ({1'b0, word_full[15:0]} > MAX_W);

    assign ld.addr = addr_q;
    assign ld.data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ld.in_ready = 1'b0;
        ld.loadIM   = 1'b0;
        core_rst    = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = HDR;
            end
            HDR: begin
                ld.in_ready = 1'b1;
                busy        = 1'b1;
                if (last_byte) begin
                    if (hdr_bad)                       state_nxt = ERR;
                    else if (word_full[15:0] == 16'd0) state_nxt = DONE;
                    else                               state_nxt = DATA;
                end
            end
            DATA: begin
                ld.in_ready = 1'b1;
                busy        = 1'b1;
                if (last_byte) state_nxt = WRITE;
            end
            WRITE: begin
                ld.loadIM = 1'b1;
                busy      = 1'b1;
                state_nxt = ((idx + 16'd1) == n_words) ? DONE : DATA;
            end
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (start) state_nxt = HDR;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_nxt = HDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= 2'd0;
            word_lo      <= 24'd0;
            n_words      <= 16'd0;
            idx          <= 16'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            if (start_ok) begin
                byte_cnt     <= 2'd0;
                words_loaded <= 16'd0;
            end
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word_lo[7:0]   <= ld.in_data;
                    2'd1:    word_lo[15:8]  <= ld.in_data;
                    2'd2:    word_lo[23:16] <= ld.in_data;
                    default: ;
                endcase
            end
            if ((state == HDR) && last_byte) begin
                n_words <= word_full[15:0];
                idx     <= 16'd0;
            end
            // address/data are registered on the last byte so they are stable for the whole WRITE cycle
            if ((state == DATA) && last_byte) begin
                addr_q <= BASE_ADDR + {14'd0, idx, 2'b00};
                data_q <= word_full;
            end
            if (state == WRITE) begin
                idx          <= idx + 16'd1;
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 0x100) see the same stream.
module tb_imem_loader;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0000_0100;

    logic clk, rst_n, start;
    logic in_valid;
    logic [7:0] in_data;
    logic core_rst0, busy0, done0, err0;
    logic core_rst1, busy1, done1, err1;
    logic [15:0] wl0, wl1;

    int checks = 0;
    int errors = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit watch = 0;
    int rst_drop = 0;

    imem_loader_if if0 ();
    imem_loader_if if1 ();

    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;

    imem_loader #(.BASE_ADDR(B0), .MAX_WORDS(1024)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .ld(if0.master),
        .core_rst(core_rst0), .busy(busy0), .done(done0), .err(err0), .words_loaded(wl0)
    );

    imem_loader #(.BASE_ADDR(B1), .MAX_WORDS(1024)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .ld(if1.master),
        .core_rst(core_rst1), .busy(busy1), .done(done1), .err(err1), .words_loaded(wl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if0.loadIM) q0.push_back({if0.addr, if0.data});
        if (if1.loadIM) q1.push_back({if1.addr, if1.data});
        if (watch && (core_rst0 !== 1'b1 || core_rst1 !== 1'b1)) rst_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // exp = {in_ready, loadIM, core_rst, busy, done, err}
    task automatic status(input string tag, input logic [5:0] exp, input logic [15:0] wl);
        chk({tag, "_st0"}, 32'({if0.in_ready, if0.loadIM, core_rst0, busy0, done0, err0}), 32'(exp));
        chk({tag, "_st1"}, 32'({if1.in_ready, if1.loadIM, core_rst1, busy1, done1, err1}), 32'(exp));
        chk({tag, "_wl0"}, 32'(wl0), 32'(wl));
        chk({tag, "_wl1"}, 32'(wl1), 32'(wl));
    endtask

    task automatic check_writes(input string tag, input int n, input logic [31:0] ed [3]);
        chk({tag, "_cnt0"}, 32'(q0.size()), 32'(n));
        chk({tag, "_cnt1"}, 32'(q1.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < q0.size()) begin
                chk({tag, "_addr0"}, q0[i][63:32], B0 + 32'(4 * i));
                chk({tag, "_data0"}, q0[i][31:0], ed[i]);
            end
            if (i < q1.size()) begin
                chk({tag, "_addr1"}, q1[i][63:32], B1 + 32'(4 * i));
                chk({tag, "_data1"}, q1[i][31:0], ed[i]);
            end
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!if0.in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit chk_rdy);
        in_valid = 1'b0;
        in_data  = 8'hEE;
        repeat (n) begin
            @(negedge clk);
            if (chk_rdy) chk("stall_rdy", 32'(if0.in_ready), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int stall);
        for (int i = 0; i < 4; i++) begin
            if (stall > 0) idle(stall, i != 0);
            send(w[8*i +: 8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        status("reset", 6'b001000, 16'd0);
        chk("reset_addr", if0.addr, 32'd0);
        chk("reset_data", if1.data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // bytes offered in IDLE must not be consumed
        in_valid = 1'b1; in_data = 8'hFF;
        tick(); tick();
        in_valid = 1'b0;
        status("idle", 6'b001000, 16'd0);

        // basic load
        do_start();
        status("hdr", 6'b101100, 16'd0);
        send_word(32'h0000_0002, 0);
        send_word(32'h0010_0513, 0);
        send_word(32'h0020_0593, 0);
        status("write", 6'b011100, 16'd1);
        chk("lat_addr0", if0.addr, 32'h4);
        chk("lat_addr1", if1.addr, 32'h104);
        chk("lat_data", if0.data, 32'h0020_0593);
        tick();
        status("basic_done", 6'b000010, 16'd2);
        check_writes("basic", 2, '{32'h0010_0513, 32'h0020_0593, 32'h0});

        // stalls between every byte, restart from DONE
        do_start();
        status("restart", 6'b101100, 16'd0);
        send_word(32'h0000_0002, 3);
        send_word(32'h0010_0513, 3);
        send_word(32'h0020_0593, 3);
        tick();
        status("stall_done", 6'b000010, 16'd2);
        check_writes("stall", 2, '{32'h0010_0513, 32'h0020_0593, 32'h0});

        // header errors
        do_start();
        send_word(32'h0000_0401, 0);
        status("err_big", 6'b001001, 16'd0);
        in_valid = 1'b1; in_data = 8'h55;
        tick(); tick();
        in_valid = 1'b0;
        status("err_hold", 6'b001001, 16'd0);
        do_start();
        status("err_restart", 6'b101100, 16'd0);
        send_word(32'h0001_0000, 0);
        status("err_hi", 6'b001001, 16'd0);
        do_start();
        status("err_clear", 6'b101100, 16'd0);

        // zero-length image
        send_word(32'h0000_0000, 0);
        status("zero", 6'b000010, 16'd0);
        check_writes("zero", 0, '{32'h0, 32'h0, 32'h0});

        // exactly MAX_WORDS is accepted
        do_start();
        send_word(32'h0000_0400, 0);
        status("max_ok", 6'b101100, 16'd0);
        @(negedge clk) rst_n = 1'b0;
        #1 status("max_rst", 6'b001000, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // reset during the second byte of word 1 of 3
        do_start();
        send_word(32'h0000_0003, 0);
        send_word(32'h0010_0513, 0);
        send(8'h93);
        in_valid = 1'b1; in_data = 8'h05;
        @(negedge clk) rst_n = 1'b0;
        #1;
        status("midrst", 6'b001000, 16'd0);
        chk("midrst_addr", if1.addr, 32'd0);
        chk("midrst_data", if0.data, 32'd0);
        in_valid = 1'b0;
        check_writes("midrst", 1, '{32'h0010_0513, 32'h0, 32'h0});
        @(negedge clk) rst_n = 1'b1;
        tick();
        do_start();
        send_word(32'h0000_0001, 0);
        send_word(32'hDDCC_BBAA, 0);
        tick();
        status("one_done", 6'b000010, 16'd1);
        check_writes("one", 1, '{32'hDDCC_BBAA, 32'h0, 32'h0});

        // reload 3 words; stray starts mid-load are ignored, core stays in reset
        do_start();
        watch = 1'b1;
        send_word(32'h0000_0003, 0);
        send_word(32'h0000_0013, 0);
        do_start();
        send_word(32'h0050_0093, 0);
        do_start();
        send_word(32'hFFFF_FFFF, 0);
        watch = 1'b0;
        tick();
        chk("reload_core_rst", 32'(rst_drop), 32'd0);
        status("reload_done", 6'b000010, 16'd3);
        check_writes("reload", 3, '{32'h0000_0013, 32'h0050_0093, 32'hFFFF_FFFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
